// File: rtl/writeback_unit.sv
// writeback_unit: register-file write stage arbitrating single-cycle ALU results
// against an in-order load queue, with WAW kill, source stalls and write bypass.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_alu_valid,
    input  logic [4:0]                 i_alu_rd,
    input  logic [31:0]                i_alu_data,
    input  logic                       i_load_valid,
    input  logic [4:0]                 i_load_rd,
    input  logic [31:0]                i_load_data,
    output logic                       o_load_ready,
    output logic                       o_write_register_enable,
    output logic [4:0]                 o_write_address,
    output logic [31:0]                o_write_back_data,
    input  logic [4:0]                 i_read_address_1,
    input  logic [4:0]                 i_read_address_2,
    output logic                       o_stall_1,
    output logic                       o_stall_2,
    output logic                       o_forward_valid_1,
    output logic                       o_forward_valid_2,
    output logic [31:0]                o_forward_data_1,
    output logic [31:0]                o_forward_data_2,
    output logic [$clog2(DEPTH):0]     o_pending_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_used, r_kill;
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic             r_wen;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;

    logic             w_alu_req, w_push, w_pop, w_head_live;
    logic [DEPTH-1:0] w_match_alu, w_live_1, w_live_2, w_used_nxt, w_kill_nxt;

    assign w_alu_req   = i_alu_valid && (i_alu_rd != 5'd0);
    assign o_load_ready = (r_count != CW'(DEPTH));
    assign w_push      = i_load_valid && o_load_ready && (i_load_rd != 5'd0);
    assign w_pop       = (r_count != '0) && !w_alu_req;
    assign w_head_live = !r_kill[r_head];

    always_comb begin
        w_match_alu = '0;
        w_live_1    = '0;
        w_live_2    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match_alu[i] = r_used[i] && (r_rd[i] == i_alu_rd);
            w_live_1[i]    = r_used[i] && !r_kill[i] && (r_rd[i] == i_read_address_1);
            w_live_2[i]    = r_used[i] && !r_kill[i] && (r_rd[i] == i_read_address_2);
        end
    end

    // A load pushed alongside an ALU write to the same rd is younger, so the
    // push clears the kill bit after the ALU match has been applied.
    always_comb begin
        w_used_nxt = r_used;
        w_kill_nxt = r_kill | (w_alu_req ? w_match_alu : '0);
        if (w_pop) begin
            w_used_nxt[r_head] = 1'b0;
            w_kill_nxt[r_head] = 1'b0;
        end
        if (w_push) begin
            w_used_nxt[r_tail] = 1'b1;
            w_kill_nxt[r_tail] = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_used  <= '0;
            r_kill  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            r_used  <= w_used_nxt;
            r_kill  <= w_kill_nxt;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_rd[r_tail]   <= i_load_rd;
                r_data[r_tail] <= i_load_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            r_wen <= w_alu_req || (w_pop && w_head_live);
            if (w_alu_req) begin
                r_waddr <= i_alu_rd;
                r_wdata <= i_alu_data;
            end else if (w_pop && w_head_live) begin
                r_waddr <= r_rd[r_head];
                r_wdata <= r_data[r_head];
            end
        end
    end

    assign o_write_register_enable = r_wen;
    assign o_write_address         = r_waddr;
    assign o_write_back_data       = r_wdata;
    assign o_pending_count         = r_count;

    assign o_stall_1 = (i_read_address_1 != 5'd0) && (|w_live_1);
    assign o_stall_2 = (i_read_address_2 != 5'd0) && (|w_live_2);

    assign o_forward_valid_1 = (i_read_address_1 != 5'd0) && r_wen && (r_waddr == i_read_address_1) && !o_stall_1;
    assign o_forward_valid_2 = (i_read_address_2 != 5'd0) && r_wen && (r_waddr == i_read_address_2) && !o_stall_2;
    assign o_forward_data_1  = o_forward_valid_1 ? r_wdata : 32'd0;
    assign o_forward_data_2  = o_forward_valid_2 ? r_wdata : 32'd0;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scenario tests for writeback_unit with
// hand-computed expectations.
module tb_writeback_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid, load_valid;
    logic [4:0]  alu_rd, load_rd, ra1, ra2;
    logic [31:0] alu_data, load_data;
    logic        load_ready, wen, stall1, stall2, fv1, fv2;
    logic [4:0]  waddr;
    logic [31:0] wdata, fd1, fd2;
    logic [2:0]  pending;
    int checks = 0;
    int errors = 0;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_load_valid(load_valid), .i_load_rd(load_rd), .i_load_data(load_data),
        .o_load_ready(load_ready),
        .o_write_register_enable(wen), .o_write_address(waddr), .o_write_back_data(wdata),
        .i_read_address_1(ra1), .i_read_address_2(ra2),
        .o_stall_1(stall1), .o_stall_2(stall2),
        .o_forward_valid_1(fv1), .o_forward_valid_2(fv2),
        .o_forward_data_1(fd1), .o_forward_data_2(fd2),
        .o_pending_count(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        load_valid = 0; load_rd = 0; load_data = 0;
        ra1 = 0; ra2 = 0;
    endtask

    task automatic test_reset;
        idle();
        ra1 = 5; ra2 = 9;
        #3;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b want 0", wen); end
        checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", load_ready); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
        checks++; if ({stall1, stall2, fv1, fv2} !== 4'b0) begin errors++; $display("FAIL reset_stall_fwd: got %b want 0000", {stall1, stall2, fv1, fv2}); end
        checks++; if (fd1 !== 32'd0) begin errors++; $display("FAIL reset_fd1: got %h want 0", fd1); end
        @(negedge clk);
        rst_n = 1;
        cyc();
    endtask

    task automatic test_alu;
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; ra1 = 5; ra2 = 6;
        cyc();
        alu_valid = 0;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL alu_wen: got %0b want 1", wen); end
        checks++; if (waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d want 5", waddr); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata: got %h want deadbeef", wdata); end
        checks++; if (fv1 !== 1'b1 || fd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_fwd1: got %0b/%h want 1/deadbeef", fv1, fd1); end
        checks++; if (fv2 !== 1'b0 || fd2 !== 32'd0) begin errors++; $display("FAIL alu_fwd2: got %0b/%h want 0/0", fv2, fd2); end
        cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL alu_idle_wen: got %0b want 0", wen); end
        checks++; if (fv1 !== 1'b0 || fd1 !== 32'd0) begin errors++; $display("FAIL alu_idle_fwd1: got %0b/%h want 0/0", fv1, fd1); end
    endtask

    task automatic test_fill;
        logic acc;
        idle();
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 9; alu_data = 32'h900 + i;
            load_valid = 1; load_rd = 5'(i); load_data = 32'h100 + i;
            cyc();
        end
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL fill_pending: got %0d want 4", pending); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", load_ready); end
        load_rd = 5; load_data = 32'h105; alu_data = 32'h905; ra1 = 3;
        #1;
        checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL fill_stall: got %0b want 1", stall1); end
        cyc();
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL fill_full_hold: got %0d want 4", pending); end
        checks++; if (wen !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h905) begin errors++; $display("FAIL fill_alu_write: got %0b/%0d/%h want 1/9/905", wen, waddr, wdata); end
        alu_valid = 0; ra1 = 0;
        for (int k = 1; k <= 5; k++) begin
            acc = load_valid && load_ready;
            cyc();
            if (acc) load_valid = 0;
            checks++; if (wen !== 1'b1 || waddr !== 5'(k) || wdata !== 32'h100 + k) begin errors++; $display("FAIL fill_drain_%0d: got %0b/%0d/%h want 1/%0d/%h", k, wen, waddr, wdata, k, 32'h100 + k); end
        end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL fill_empty: got %0d want 0", pending); end
        cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL fill_after_wen: got %0b want 0", wen); end
    endtask

    task automatic test_kill;
        idle();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h1; load_valid = 1; load_rd = 7; load_data = 32'h11;
        cyc();
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL kill_pending_q: got %0d want 1", pending); end
        load_valid = 0; alu_rd = 7; alu_data = 32'h22; ra1 = 7;
        #1;
        checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL kill_stall_before: got %0b want 1", stall1); end
        cyc();
        alu_valid = 0;
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL kill_stall_after: got %0b want 0", stall1); end
        checks++; if (wen !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h22) begin errors++; $display("FAIL kill_alu_write: got %0b/%0d/%h want 1/7/22", wen, waddr, wdata); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL kill_pending_killed: got %0d want 1", pending); end
        checks++; if (fv1 !== 1'b1 || fd1 !== 32'h22) begin errors++; $display("FAIL kill_fwd: got %0b/%h want 1/22", fv1, fd1); end
        cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL kill_pop_wen: got %0b want 0", wen); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL kill_pop_pending: got %0d want 0", pending); end
        checks++; if (fv1 !== 1'b0 || fd1 !== 32'd0) begin errors++; $display("FAIL kill_pop_fwd: got %0b/%h want 0/0", fv1, fd1); end
    endtask

    task automatic test_same_edge;
        idle();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hBB;
        load_valid = 1; load_rd = 3; load_data = 32'hAA; ra1 = 3; ra2 = 3;
        cyc();
        alu_valid = 0; load_valid = 0;
        #1;
        checks++; if (wen !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hBB) begin errors++; $display("FAIL same_first: got %0b/%0d/%h want 1/3/bb", wen, waddr, wdata); end
        checks++; if (stall1 !== 1'b1 || pending !== 3'd1) begin errors++; $display("FAIL same_stall: got %0b/%0d want 1/1", stall1, pending); end
        checks++; if (fv1 !== 1'b0 || fd1 !== 32'd0) begin errors++; $display("FAIL same_fwd_blocked: got %0b/%h want 0/0", fv1, fd1); end
        cyc();
        checks++; if (wen !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAA) begin errors++; $display("FAIL same_second: got %0b/%0d/%h want 1/3/aa", wen, waddr, wdata); end
        checks++; if (stall1 !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL same_unstall: got %0b/%0d want 0/0", stall1, pending); end
        checks++; if (fv2 !== 1'b1 || fd2 !== 32'hAA) begin errors++; $display("FAIL same_fwd2: got %0b/%h want 1/aa", fv2, fd2); end
        cyc();
    endtask

    task automatic test_back_to_back;
        idle();
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'hA0 + i; ra1 = 5'(i);
            cyc();
            checks++; if (wen !== 1'b1 || waddr !== 5'(i) || wdata !== 32'hA0 + i) begin errors++; $display("FAIL b2b_%0d: got %0b/%0d/%h want 1/%0d/%h", i, wen, waddr, wdata, i, 32'hA0 + i); end
            checks++; if (fv1 !== 1'b1 || fd1 !== 32'hA0 + i) begin errors++; $display("FAIL b2b_fwd_%0d: got %0b/%h want 1/%h", i, fv1, fd1, 32'hA0 + i); end
        end
        idle();
        cyc();
    endtask

    task automatic test_x0;
        idle();
        load_valid = 1; load_rd = 0; load_data = 32'h5;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h6;
        cyc();
        idle();
        #1;
        checks++; if (pending !== 3'd0 || wen !== 1'b0) begin errors++; $display("FAIL x0_first: got %0d/%0b want 0/0", pending, wen); end
        cyc();
        checks++; if (pending !== 3'd0 || wen !== 1'b0) begin errors++; $display("FAIL x0_second: got %0d/%0b want 0/0", pending, wen); end
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 20; alu_data = 32'(i);
            load_valid = 1; load_rd = 5'(10 + i); load_data = 32'h200 + i;
            cyc();
        end
        idle();
        ra2 = 11;
        #1;
        checks++; if (pending !== 3'd3 || stall2 !== 1'b1) begin errors++; $display("FAIL x0_queued: got %0d/%0b want 3/1", pending, stall2); end
        #1 rst_n = 0;
        #1;
        checks++; if (pending !== 3'd0 || load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_queue: got %0d/%0b want 0/1", pending, load_ready); end
        checks++; if (wen !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL rst_mid_w: got %0b/%0d/%h want 0/0/0", wen, waddr, wdata); end
        checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0b want 0", stall2); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++; if (wen !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL rst_release_%0d: got %0b/%0d want 0/0", k, wen, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fill();
        test_kill();
        test_same_edge();
        test_back_to_back();
        test_x0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of load-queue entries (power of two, 2..16).
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in 32: single-cycle result, always accepted, no ready.
REQ-005 SHALL have ports load_valid in 1, load_rd in 5, load_data in 32, load_ready out 1: load result, valid/ready handshake.
REQ-006 SHALL have ports write_register_enable out 1, write_address out 5, write_back_data out 32: the register-file write port, all registered.
REQ-007 SHALL have ports read_address_1, read_address_2  in  5: decode-stage source addresses.
REQ-008 SHALL have ports stall_1, stall_2  out  1: source N awaits a queued load.
REQ-009 SHALL have ports forward_valid_1, forward_valid_2 out 1 and forward_data_1, forward_data_2 out 32: bypass of the in-flight write.
REQ-010 SHALL have port pending_count  out  $clog2(DEPTH)+1  current load-queue occupancy, killed entries included.

Function
REQ-011 SHALL hold a write stage W = {en, addr, data} driving REQ-006 outputs directly; one-cycle latency from acceptance to write_register_enable.
REQ-012 SHALL treat alu_valid with alu_rd=0 as no ALU request.
REQ-013 SHALL, per edge, load W with priority: ALU request; else live queue head (popped); else W.en=0.
REQ-014 SHALL pop a killed head without writing (W.en=0) in any cycle with no ALU request.
REQ-015 SHALL drive load_ready = (pending_count < DEPTH), from registered state only, no combinational path from any input.
REQ-016 SHALL accept a load when load_valid && load_ready; load_rd=0 is accepted and discarded, not enqueued.
REQ-017 SHALL allow push and pop in the same edge; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-018 SHALL, when an ALU request is accepted, set the kill bit on every queued entry with matching rd (WAW ordering: ALU is younger).
REQ-019 SHALL treat a load pushed in the same edge as an ALU request to the same rd as younger: not killed.
REQ-020 SHALL assert stall_N when read_address_N != 0 and it matches any live (unkilled) queued entry; combinational from state and read_address_N.
REQ-021 SHALL assert forward_valid_N with forward_data_N = W.data when read_address_N != 0, W.en=1, W.addr matches, and stall_N=0; else forward_data_N = 0.
REQ-022 SHALL never assert write_register_enable with write_address=0.

Reset
REQ-023 SHALL, on reset=0 at any time, empty the queue and clear kill bits, W.en=0, write_address=0, write_back_data=0.
REQ-024 SHALL drive, during and after reset: load_ready=1, pending_count=0, stall_N=0, forward_valid_N=0, forward_data_N=0.
REQ-025 SHALL discard queued loads when reset asserts mid-operation; none are written after release.

Verification
REQ-026 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at edge k -> after edge k, enable=1, address=5, data=0xDEADBEEF; read_address_1=5 -> forward_valid_1=1, forward_data_1=0xDEADBEEF.
REQ-027 Queue fill: 5 back-to-back loads (rd 1..5) with alu_valid=1 (rd 9) every cycle -> 4 accepted, load_ready=0, pending_count=4; drop alu_valid -> rd 1..4 written in order on 4 consecutive cycles, then rd 5.
REQ-028 Kill: queue load rd=7 data=0x11 behind ALU traffic, then ALU rd=7 data=0x22 -> stall_1 on read_address_1=7 drops after ALU edge; x7 written 0x22 only; killed entry popped with enable=0.
REQ-029 Same-edge load and ALU, both rd=3 (load 0xAA, ALU 0xBB) -> 0xBB written first, 0xAA written later; stall_1 on rd 3 until pop.
REQ-030 x0 handling: load rd=0 and ALU rd=0 -> pending_count stays 0, enable never asserts; reset pulsed with 3 queued loads -> pending_count=0, load_ready=1, no writes after release.
